// File: rtl/pulse_meter.sv
// Pulse-width meter: synchronizes sig_in and measures how long it stays high,
// in whole seconds of CLK_CYCLES_PER_SECOND clk cycles, saturating at 31.
// Ports:
//   clk, rst (async, active-high)
//   sig_in        asynchronous pulse under measurement
//   meas_ready    consumer accepts the result while meas_valid is high
//   meas_valid    result available, held until accepted
//   meas_sec[4:0] measured high time in seconds (saturates at 31)
//   meas_ovf      more than 31 whole seconds were counted
//   busy          a pulse is currently being measured
//   pulse_dropped one-cycle strobe: a rise arrived while a result was pending
module pulse_meter #(
    parameter int CLK_CYCLES_PER_SECOND = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    input  logic       meas_ready,
    output logic       meas_valid,
    output logic [4:0] meas_sec,
    output logic       meas_ovf,
    output logic       busy,
    output logic       pulse_dropped
);

    localparam int CW = (CLK_CYCLES_PER_SECOND > 2) ?
                        $clog2(CLK_CYCLES_PER_SECOND) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(CLK_CYCLES_PER_SECOND - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          s3_q, s3_d;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [4:0]    sec_cnt_q, sec_cnt_d;
    logic          ovf_acc_q, ovf_acc_d;
    logic          meas_valid_q, meas_valid_d;
    logic [4:0]    meas_sec_q, meas_sec_d;
    logic          meas_ovf_q, meas_ovf_d;
    logic          busy_q, busy_d;
    logic          pulse_dropped_q, pulse_dropped_d;
    logic          rise;

    // s3 only remembers the previous synchronized level for edge detection.
    assign rise = s2_q & ~s3_q;

    always_comb begin
        s1_d            = sig_in;
        s2_d            = s1_q;
        s3_d            = s2_q;
        state_d         = state_q;
        cycle_cnt_d     = cycle_cnt_q;
        sec_cnt_d       = sec_cnt_q;
        ovf_acc_d       = ovf_acc_q;
        meas_valid_d    = meas_valid_q;
        meas_sec_d      = meas_sec_q;
        meas_ovf_d      = meas_ovf_q;
        pulse_dropped_d = 1'b0;

        case (state_q)
            IDLE: begin
                // The rising cycle itself is the first counted high cycle.
                if (rise) begin
                    state_d     = MEASURE;
                    cycle_cnt_d = CW'(1);
                    sec_cnt_d   = 5'd0;
                    ovf_acc_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (s2_q) begin
                    if (cycle_cnt_q == LAST_CYC) begin
                        cycle_cnt_d = '0;
                        // Saturate instead of wrapping; remember the overflow.
                        if (sec_cnt_q == 5'd31) begin
                            ovf_acc_d = 1'b1;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 5'd1;
                        end
                    end else begin
                        cycle_cnt_d = cycle_cnt_q + CW'(1);
                    end
                end else begin
                    state_d      = DONE;
                    meas_sec_d   = sec_cnt_q;
                    meas_ovf_d   = ovf_acc_q;
                    meas_valid_d = 1'b1;
                end
            end
            DONE: begin
                // A pulse starting while the result is pending is lost.
                if (rise) begin
                    pulse_dropped_d = 1'b1;
                end
                if (meas_ready) begin
                    state_d      = IDLE;
                    meas_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MEASURE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            s1_q            <= 1'b0;
            s2_q            <= 1'b0;
            s3_q            <= 1'b0;
            cycle_cnt_q     <= '0;
            sec_cnt_q       <= 5'd0;
            ovf_acc_q       <= 1'b0;
            meas_valid_q    <= 1'b0;
            meas_sec_q      <= 5'd0;
            meas_ovf_q      <= 1'b0;
            busy_q          <= 1'b0;
            pulse_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            s1_q            <= s1_d;
            s2_q            <= s2_d;
            s3_q            <= s3_d;
            cycle_cnt_q     <= cycle_cnt_d;
            sec_cnt_q       <= sec_cnt_d;
            ovf_acc_q       <= ovf_acc_d;
            meas_valid_q    <= meas_valid_d;
            meas_sec_q      <= meas_sec_d;
            meas_ovf_q      <= meas_ovf_d;
            busy_q          <= busy_d;
            pulse_dropped_q <= pulse_dropped_d;
        end
    end

    assign meas_valid    = meas_valid_q;
    assign meas_sec      = meas_sec_q;
    assign meas_ovf      = meas_ovf_q;
    assign busy          = busy_q;
    assign pulse_dropped = pulse_dropped_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: directed boundary pulses plus random
// pulse widths and accept delays, checked against arithmetic expectations.
module tb_pulse_meter;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig_in;
    logic       meas_ready;
    logic       meas_valid;
    logic [4:0] meas_sec;
    logic       meas_ovf;
    logic       busy;
    logic       pulse_dropped;

    int n_checks = 0;
    int n_errors = 0;

    int busy_cnt  = 0;
    int drop_cnt  = 0;
    int rises     = 0;
    logic valid_prev = 1'b0;

    pulse_meter #(.CLK_CYCLES_PER_SECOND(N)) dut (
        .clk(clk),
        .rst(rst),
        .sig_in(sig_in),
        .meas_ready(meas_ready),
        .meas_valid(meas_valid),
        .meas_sec(meas_sec),
        .meas_ovf(meas_ovf),
        .busy(busy),
        .pulse_dropped(pulse_dropped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (pulse_dropped) drop_cnt++;
        if (meas_valid && !valid_prev) rises++;
        valid_prev = meas_valid;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_sec(input int k);
        return (k / N > 31) ? 31 : k / N;
    endfunction

    function automatic int exp_ovf(input int k);
        return (k / N > 31) ? 1 : 0;
    endfunction

    // sig_in has been sampled high on k edges; drop it and check the result.
    // hold = cycles to keep meas_ready low after meas_valid appears.
    task automatic finish_pulse(input int k, input int hold);
        int lat;
        int r0;
        int d0;
        bit got;
        bit stable;
        r0 = rises;
        d0 = drop_cnt;
        meas_ready = (hold == 0);
        sig_in = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (meas_valid) got = 1'b1;
        end
        check("valid_seen", int'(got), 1);
        check("latency", lat, 3);
        check("sec", int'(meas_sec), exp_sec(k));
        check("ovf", int'(meas_ovf), exp_ovf(k));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!meas_valid || meas_sec !== 5'(exp_sec(k))) stable = 1'b0;
        end
        if (hold > 0) begin
            check("hold_stable", int'(stable), 1);
            meas_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("accepted", int'(meas_valid), 0);
        check("sec_kept", int'(meas_sec), exp_sec(k));
        meas_ready = 1'b0;
        check("busy_cycles", busy_cnt, k);
        check("one_result", rises - r0, 1);
        check("no_drop", drop_cnt - d0, 0);
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1;
    endtask

    task automatic run_pulse(input int k, input int hold);
        busy_cnt = 0;
        sig_in = 1'b1;
        repeat (k) @(posedge clk);
        #1;
        finish_pulse(k, hold);
    endtask

    initial begin
        int bounds[8];
        int r0;
        int d0;
        bit stable;
        bounds = '{35, 9, 10, 19, 20, 319, 330, 1};
        rst = 1'b1;
        sig_in = 1'b0;
        meas_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(meas_valid), 0);
        check("rst_sec", int'(meas_sec), 0);
        check("rst_ovf", int'(meas_ovf), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(pulse_dropped), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        foreach (bounds[i]) run_pulse(bounds[i], 0);

        for (int i = 0; i < 12; i++) begin
            run_pulse($urandom_range(1, 360),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0);
        end

        // Second pulse arrives while the first result waits for acceptance.
        r0 = rises;
        d0 = drop_cnt;
        busy_cnt = 0;
        meas_ready = 1'b0;
        sig_in = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        sig_in = 1'b0;
        for (int i = 0; i < 40 && !meas_valid; i++) begin
            @(posedge clk); #1;
        end
        check("drop_valid", int'(meas_valid), 1);
        check("drop_sec", int'(meas_sec), 2);
        stable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            sig_in = (c >= 5 && c < 17);
            @(posedge clk); #1;
            if (!meas_valid || meas_sec !== 5'd2) stable = 1'b0;
        end
        check("drop_stable", int'(stable), 1);
        check("drop_strobe", drop_cnt - d0, 1);
        meas_ready = 1'b1;
        @(posedge clk); #1;
        meas_ready = 1'b0;
        check("drop_accept", int'(meas_valid), 0);
        repeat (30) @(posedge clk);
        #1;
        check("drop_no_second", rises - r0, 1);
        check("drop_busy", busy, 0);

        // Asynchronous reset in the middle of a 50-cycle pulse.
        busy_cnt = 0;
        sig_in = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_valid", int'(meas_valid), 0);
        check("arst_sec", int'(meas_sec), 0);
        check("arst_ovf", int'(meas_ovf), 0);
        check("arst_drop", int'(pulse_dropped), 0);
        @(negedge clk);
        rst = 1'b0;
        r0 = rises;
        busy_cnt = 0;
        repeat (35) @(posedge clk);
        #1;
        check("rst_no_valid", rises - r0, 0);
        finish_pulse(35, 0);

        // sig_in already high when reset is released counts as a rise.
        sig_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        repeat (22) @(posedge clk);
        #1;
        finish_pulse(22, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter CLK_CYCLES_PER_SECOND, default 10, clk cycles per counted second; legal values >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sig_in  input  1  asynchronous pulse to be measured; high time is measured.
REQ-005 meas_ready  input  1  consumer accepts result when high together with meas_valid.
REQ-006 meas_valid  output  1  result available; held until accepted.
REQ-007 meas_sec  output  5  measured high time in whole seconds, saturating at 31.
REQ-008 meas_ovf  output  1  high time exceeded 31 s of counted seconds.
REQ-009 busy  output  1  high while a pulse is being measured (state MEASURE).
REQ-010 pulse_dropped  output  1  one-cycle strobe: a rising edge arrived while a result awaited acceptance.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3, fall = ~s2.
REQ-012 State machine SHALL have states IDLE, MEASURE, DONE; encoding free.
REQ-013 IDLE: on rise -> MEASURE, cycle_cnt <= 1, sec_cnt <= 0, ovf_acc <= 0; otherwise stay.
REQ-014 MEASURE, s2 high: if cycle_cnt == CLK_CYCLES_PER_SECOND-1 then cycle_cnt <= 0 and sec_cnt increments; else cycle_cnt increments.
REQ-015 Second completion with sec_cnt == 31 SHALL leave sec_cnt at 31 and set ovf_acc <= 1 (saturation, no wrap).
REQ-016 Result for K synchronized high cycles SHALL be meas_sec = min(floor(K / CLK_CYCLES_PER_SECOND), 31); meas_ovf = 1 iff floor(K / CLK_CYCLES_PER_SECOND) > 31.
REQ-017 MEASURE, fall: -> DONE; meas_sec <= sec_cnt, meas_ovf <= ovf_acc, meas_valid <= 1 on the same edge.
REQ-018 Latency: meas_valid SHALL rise on the 3rd clk edge after the first edge that samples sig_in low.
REQ-019 DONE: meas_valid, meas_sec, meas_ovf SHALL hold stable while meas_ready is low.
REQ-020 DONE with meas_ready high: -> IDLE, meas_valid <= 0 on that edge; meas_sec/meas_ovf keep last value until next DONE entry.
REQ-021 Rise detected in DONE (including the accepting cycle) SHALL pulse pulse_dropped for exactly one cycle and SHALL NOT start a measurement; that pulse is lost.
REQ-022 IDLE SHALL start only on a rise edge; sig_in already high on IDLE entry is ignored until it falls and rises again.
REQ-023 busy SHALL equal (state == MEASURE), registered.
REQ-024 meas_ready while meas_valid low SHALL have no effect.

Reset
REQ-025 rst high SHALL immediately force state IDLE and clear s1, s2, s3, cycle_cnt, sec_cnt, ovf_acc, meas_valid, meas_sec, meas_ovf, busy, pulse_dropped to 0, independent of clk.
REQ-026 Reset mid-MEASURE or mid-DONE SHALL discard the measurement/result; no meas_valid follows.
REQ-027 sig_in already high at reset release SHALL count as a rise (synchronizer clears to 0), measurement starts ~2 edges later.

Verification (CLK_CYCLES_PER_SECOND = 10)
REQ-028 sig_in high 35 cycles, meas_ready=1 -> meas_valid 1 cycle, meas_sec=3, meas_ovf=0, valid 3 edges after fall; busy high 35 cycles.
REQ-029 Boundaries: high 9 -> 0; 10 -> 1; 19 -> 1; 20 -> 2 (each with meas_ovf=0).
REQ-030 High 319 cycles -> meas_sec=31, meas_ovf=0; high 330 cycles -> meas_sec=31, meas_ovf=1.
REQ-031 Pulse 25 cycles, meas_ready=0 for 40 cycles, second 12-cycle pulse during DONE -> meas_valid held, meas_sec=2 stable, pulse_dropped one cycle; meas_ready=1 -> meas_valid 0 next edge, state IDLE, no second result.
REQ-032 rst asserted asynchronously at cycle 15 of a 50-cycle pulse -> all outputs 0 before next clk edge, no meas_valid after release while sig_in still high.
REQ-033 sig_in high across rst release for 22 cycles -> one result, meas_sec=2.
